// File: rtl/perf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// perf_counter_ctrl : memory-mapped performance counters with cache latency tracking
// Revision 1.0
// ============================================================================
module perf_counter_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        ctr_hit,
  output logic [31:0] ctr_rdata,
  output logic        ctr_resp,
  input  logic        instr_req,
  input  logic        data_req,
  input  logic        l1_req,
  input  logic        instr_resp,
  input  logic        data_resp,
  input  logic        l1_resp,
  input  logic        br_resolve,
  input  logic        br_correct,
  input  logic        count_en
);

  localparam int unsigned C_NUM_CTR = 8;
  localparam int unsigned C_NUM_CH  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ch_state_e;

  ch_state_e   r_state     [C_NUM_CH];
  ch_state_e   w_state_nxt [C_NUM_CH];
  logic [31:0] r_ctr       [C_NUM_CTR];
  logic [31:0] r_rdata;
  logic        r_resp;

  logic [2:0]  w_req;
  logic [2:0]  w_resp;
  logic [2:0]  w_active;
  logic [7:0]  w_inc;
  logic [2:0]  w_idx;
  logic        w_hit;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_unused;

  assign w_hit    = (mem_address[31:5] == 27'd0);
  assign w_idx    = mem_address[4:2];
  assign w_wr_en  = w_hit & mem_write;
  assign w_rd_en  = w_hit & mem_read;
  assign w_unused = ^mem_address[1:0];

  assign ctr_hit    = w_hit;
  assign dmem_read  = mem_read & ~w_hit;
  assign dmem_write = mem_write & ~w_hit;
  assign ctr_rdata  = r_rdata;
  assign ctr_resp   = r_resp;

  assign w_req  = {l1_req, data_req, instr_req};
  assign w_resp = {l1_resp, data_resp, instr_resp};

  // Channel FSMs track regardless of count_en so latency stays consistent.
  always_comb begin
    for (int c = 0; c < C_NUM_CH; c++) begin
      w_state_nxt[c] = r_state[c];
      w_active[c]    = (r_state[c] == ST_BUSY) | w_req[c];
      case (r_state[c])
        ST_IDLE: if (w_req[c] && !w_resp[c]) w_state_nxt[c] = ST_BUSY;
        ST_BUSY: if (w_resp[c])              w_state_nxt[c] = ST_IDLE;
        default: w_state_nxt[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < C_NUM_CH; c++) r_state[c] <= ST_IDLE;
    end else begin
      for (int c = 0; c < C_NUM_CH; c++) r_state[c] <= w_state_nxt[c];
    end
  end

  // Index map: 0-2 access counts, 3-5 busy cycles, 6 predictions, 7 correct.
  always_comb begin
    w_inc      = 8'd0;
    w_inc[2:0] = w_resp & w_active & {3{count_en}};
    w_inc[5:3] = w_active & {3{count_en}};
    w_inc[6]   = br_resolve & count_en;
    w_inc[7]   = br_resolve & br_correct & count_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM_CTR; i++) r_ctr[i] <= 32'd0;
    end else begin
      for (int i = 0; i < C_NUM_CTR; i++) begin
        if (w_wr_en && (w_idx == 3'(i)))
          r_ctr[i] <= mem_wdata;
        else if (w_inc[i] && (r_ctr[i] != 32'hFFFF_FFFF))
          r_ctr[i] <= r_ctr[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_resp  <= 1'b0;
    end else begin
      r_resp <= w_rd_en | w_wr_en;
      if (w_rd_en)
        r_rdata <= r_ctr[w_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// tb_perf_counter_ctrl : table-driven and directed-sequence bench
// Revision 1.0
// ============================================================================
module tb_perf_counter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic        dmem_read, dmem_write, ctr_hit, ctr_resp;
  logic [31:0] ctr_rdata;
  logic        instr_req, data_req, l1_req;
  logic        instr_resp, data_resp, l1_resp;
  logic        br_resolve, br_correct, count_en;

  int n_cmp;
  int n_err;

  perf_counter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .ctr_hit(ctr_hit), .ctr_rdata(ctr_rdata), .ctr_resp(ctr_resp),
    .instr_req(instr_req), .data_req(data_req), .l1_req(l1_req),
    .instr_resp(instr_resp), .data_resp(data_resp), .l1_resp(l1_resp),
    .br_resolve(br_resolve), .br_correct(br_correct), .count_en(count_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic        exp_dmem_rd;
    logic        exp_dmem_wr;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_ctr(input int idx, input logic [31:0] exp, input string name);
    mem_read    = 1'b1;
    mem_address = 32'(idx * 4);
    tick();
    chk({name, "_resp"}, 32'(ctr_resp), 32'd1);
    chk(name, ctr_rdata, exp);
    mem_read = 1'b0;
  endtask

  task automatic write_ctr(input int idx, input logic [31:0] data);
    mem_write   = 1'b1;
    mem_address = 32'(idx * 4);
    mem_wdata   = data;
    tick();
    mem_write = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'd0; mem_wdata = 32'd0;
    instr_req = 1'b0; data_req = 1'b0; l1_req = 1'b0;
    instr_resp = 1'b0; data_resp = 1'b0; l1_resp = 1'b0;
    br_resolve = 1'b0; br_correct = 1'b0; count_en = 1'b1;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
    vecs[8]  = '{1'b0, 1'b1, 32'h08, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
    vecs[9]  = '{1'b1, 1'b0, 32'h08, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h1234};
    vecs[10] = '{1'b1, 1'b0, 32'h40, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'h1234};
    vecs[11] = '{1'b0, 1'b1, 32'h40, 32'h5,    1'b0, 1'b0, 1'b1, 1'b0, 32'h1234};
    vecs[12] = '{1'b1, 1'b1, 32'h08, 32'hABCD, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234};
    vecs[13] = '{1'b0, 1'b1, 32'h00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h1234};
    vecs[14] = '{1'b1, 1'b0, 32'h08, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'hABCD};
    vecs[15] = '{1'b1, 1'b0, 32'h20, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 32'hABCD};
    vecs[16] = '{1'b0, 1'b0, 32'h00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD};
    vecs[17] = '{1'b0, 1'b1, 32'h08, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'hABCD};
    vecs[18] = '{1'b1, 1'b0, 32'h1F, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[19] = '{1'b1, 1'b0, 32'h1C, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

    tick();
    tick();
    chk("reset_resp", 32'(ctr_resp), 32'd0);
    chk("reset_rdata", ctr_rdata, 32'd0);
    chk("reset_dmem_read", 32'(dmem_read), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      mem_read    = vecs[i].rd;
      mem_write   = vecs[i].wr;
      mem_address = vecs[i].addr;
      mem_wdata   = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_hit", i), 32'(ctr_hit), 32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_dmem_read", i), 32'(dmem_read), 32'(vecs[i].exp_dmem_rd));
      chk($sformatf("vec%0d_dmem_write", i), 32'(dmem_write), 32'(vecs[i].exp_dmem_wr));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_resp", i), 32'(ctr_resp), 32'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_rdata", i), ctr_rdata, vecs[i].exp_rdata);
    end
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'd0;
    tick();

    // Five-cycle instruction access, then a single-cycle one, then a stray resp.
    instr_req = 1'b1;
    repeat (4) tick();
    instr_resp = 1'b1;
    tick();
    instr_req = 1'b0; instr_resp = 1'b0;
    read_ctr(3, 32'd5, "instr_cycles_5");
    read_ctr(0, 32'd1, "instr_access_1");
    instr_req = 1'b1; instr_resp = 1'b1;
    tick();
    instr_req = 1'b0; instr_resp = 1'b0;
    read_ctr(3, 32'd6, "instr_cycles_single");
    read_ctr(0, 32'd2, "instr_access_single");
    instr_resp = 1'b1;
    tick();
    instr_resp = 1'b0;
    read_ctr(0, 32'd2, "instr_stray_resp");

    // Read sees the value from before the same-cycle increment.
    instr_req = 1'b1; instr_resp = 1'b1;
    read_ctr(3, 32'd6, "read_pre_increment");
    instr_req = 1'b0; instr_resp = 1'b0;
    read_ctr(3, 32'd7, "read_post_increment");

    // Saturation of the data-cycle counter.
    write_ctr(4, 32'hFFFF_FFFE);
    data_req = 1'b1;
    tick();
    tick();
    data_resp = 1'b1;
    tick();
    data_req = 1'b0; data_resp = 1'b0;
    read_ctr(4, 32'hFFFF_FFFF, "data_cycles_saturate");
    read_ctr(1, 32'd1, "data_access_1");

    // Write beats same-cycle increment on counter 6; counter 7 still counts.
    br_resolve = 1'b1; br_correct = 1'b1;
    write_ctr(6, 32'h10);
    br_resolve = 1'b0; br_correct = 1'b0;
    read_ctr(6, 32'h10, "pred_write_priority");
    read_ctr(7, 32'd1, "correct_pred_count");

    // Frozen counting during an L1 access; the FSM must still return to IDLE.
    count_en = 1'b0;
    l1_req = 1'b1;
    repeat (3) tick();
    l1_resp = 1'b1;
    tick();
    l1_req = 1'b0; l1_resp = 1'b0;
    write_ctr(5, 32'h7);
    count_en = 1'b1;
    read_ctr(2, 32'd0, "l1_access_frozen");
    read_ctr(5, 32'h7, "l1_write_while_frozen");
    l1_resp = 1'b1;
    tick();
    l1_resp = 1'b0;
    read_ctr(2, 32'd0, "l1_fsm_idle_after_frozen");

    // Reset in the middle of an instruction access.
    instr_req = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rdata", ctr_rdata, 32'd0);
    instr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    instr_resp = 1'b1;
    tick();
    instr_resp = 1'b0;
    for (int i = 0; i < 8; i++)
      read_ctr(i, 32'd0, $sformatf("post_reset_ctr%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
